// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller <-> datapath signals of the multi-cycle MIPS CPU.
// master = control FSM, slave = datapath.
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, ir_write, reg_write, mem_read, mem_write, iord, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, ir_write, reg_write, mem_read, mem_write, iord, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM (fetch/decode/execute/memory/write-back).
// Performance counters are built only when MC_CTRL_PERF_CNT_EN is defined.
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_ctrl_if.master        dp,
    output logic             instr_done,
    output logic             halted,
    output logic             trap,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXECUTE,
        S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_EXEC, S_ADDI_WB, S_HALT, S_TRAP
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010,
                           ALU_SUB = 3'b110, ALU_SLT = 3'b111;
    localparam int WW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t        cur, nxt;
    logic [WW-1:0] wait_cnt;
    logic          timeout;

    // Traps only on the cycle the count would reach MEM_TIMEOUT; mem_ready on that cycle still wins.
    assign timeout = (MEM_TIMEOUT != 0) && !dp.mem_ready && wait_cnt == WW'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cur      <= S_RESET;
            wait_cnt <= '0;
        end else begin
            cur      <= nxt;
            wait_cnt <= (nxt != cur) ? '0 : wait_cnt + WW'(!dp.mem_ready);
        end

    always_comb begin
        nxt           = cur;
        dp.pc_en      = 1'b0;
        dp.ir_write   = 1'b0;
        dp.reg_write  = 1'b0;
        dp.mem_read   = 1'b0;
        dp.mem_write  = 1'b0;
        dp.iord       = 1'b0;
        dp.reg_dst    = 1'b0;
        dp.mem_to_reg = 1'b0;
        dp.alu_src_a  = 1'b0;
        dp.alu_src_b  = 2'b00;
        dp.alu_op     = ALU_AND;
        dp.pc_source  = 2'b00;
        instr_done    = 1'b0;
        case (cur)
            S_RESET: nxt = S_FETCH;
            S_FETCH: begin
                dp.mem_read  = 1'b1;
                dp.alu_src_b = 2'b01;
                dp.alu_op    = ALU_ADD;
                dp.ir_write  = dp.mem_ready;
                dp.pc_en     = dp.mem_ready;
                nxt          = dp.mem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
            end
            S_DECODE: begin
                dp.alu_src_b = 2'b11;
                dp.alu_op    = ALU_ADD;
                case (dp.opcode)
                    6'b100011, 6'b101011: nxt = S_MEM_ADDR;
                    6'b000000:            nxt = S_EXECUTE;
                    6'b000100:            nxt = S_BRANCH;
                    6'b000010:            nxt = S_JUMP;
                    6'b001000:            nxt = S_ADDI_EXEC;
                    6'b111111:            nxt = S_HALT;
                    default:              nxt = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                dp.alu_src_a = 1'b1;
                dp.alu_src_b = 2'b10;
                dp.alu_op    = ALU_ADD;
                nxt          = dp.opcode == 6'b101011 ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                dp.mem_read = 1'b1;
                dp.iord     = 1'b1;
                nxt         = dp.mem_ready ? S_MEM_WB : timeout ? S_TRAP : S_MEM_READ;
            end
            S_MEM_WB: begin
                dp.reg_write  = 1'b1;
                dp.mem_to_reg = 1'b1;
                instr_done    = 1'b1;
                nxt           = S_FETCH;
            end
            S_MEM_WRITE: begin
                dp.mem_write = 1'b1;
                dp.iord      = 1'b1;
                instr_done   = dp.mem_ready;
                nxt          = dp.mem_ready ? S_FETCH : timeout ? S_TRAP : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                dp.alu_src_a = 1'b1;
                nxt          = S_ALU_WB;
                case (dp.funct)
                    6'b100000: dp.alu_op = ALU_ADD;
                    6'b100010: dp.alu_op = ALU_SUB;
                    6'b100100: dp.alu_op = ALU_AND;
                    6'b100101: dp.alu_op = ALU_OR;
                    6'b101010: dp.alu_op = ALU_SLT;
                    default:   nxt = S_TRAP;
                endcase
            end
            S_ALU_WB: begin
                dp.reg_write = 1'b1;
                dp.reg_dst   = 1'b1;
                instr_done   = 1'b1;
                nxt          = S_FETCH;
            end
            S_BRANCH: begin
                dp.alu_src_a = 1'b1;
                dp.alu_op    = ALU_SUB;
                dp.pc_source = 2'b01;
                dp.pc_en     = dp.zero;
                instr_done   = 1'b1;
                nxt          = S_FETCH;
            end
            S_JUMP: begin
                dp.pc_source = 2'b10;
                dp.pc_en     = 1'b1;
                instr_done   = 1'b1;
                nxt          = S_FETCH;
            end
            S_ADDI_EXEC: begin
                dp.alu_src_a = 1'b1;
                dp.alu_src_b = 2'b10;
                dp.alu_op    = ALU_ADD;
                nxt          = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                dp.reg_write = 1'b1;
                instr_done   = 1'b1;
                nxt          = S_FETCH;
            end
            default: nxt = cur == S_HALT ? S_HALT : S_TRAP;
        endcase
    end

    assign state  = cur;
    assign halted = cur == S_HALT;
    assign trap   = cur == S_TRAP;

`ifdef MC_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (!(cur inside {S_RESET, S_HALT, S_TRAP})) cycle_count <= cycle_count + 1'b1;
            if (instr_done) instr_count <= instr_count + 1'b1;
        end
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif
endmodule
